// File: rtl/ysyx_23060208_lsu.sv
// Load/store unit: accepts one EXU request at a time and carries it out
// over an AXI-lite style data-SRAM port. The result is held for the WBU
// until it is taken.
module ysyx_23060208_lsu #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,

   // EXU request
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [1:0]            in_op,
   input  logic [2:0]            in_funct3,
   input  logic [ADDR_WIDTH-1:0] in_addr,
   input  logic [DATA_WIDTH-1:0] in_wdata,

   // WBU result
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_rdata,
   output logic                  out_err,

   // Data SRAM write address
   output logic [ADDR_WIDTH-1:0] dsram_awaddr,
   output logic                  dsram_awvalid,
   input  logic                  dsram_awready,

   // Data SRAM write data
   output logic [DATA_WIDTH-1:0] dsram_wdata,
   output logic [2:0]            dsram_wstrb,
   output logic                  dsram_wvalid,
   input  logic                  dsram_wready,

   // Data SRAM write response
   input  logic [1:0]            dsram_bresp,
   input  logic                  dsram_bvalid,
   output logic                  dsram_bready,

   // Data SRAM read address
   output logic [ADDR_WIDTH-1:0] dsram_araddr,
   output logic                  dsram_arvalid,
   input  logic                  dsram_arready,

   // Data SRAM read data
   input  logic [DATA_WIDTH-1:0] dsram_rdata,
   input  logic [1:0]            dsram_rresp,
   input  logic                  dsram_rvalid,
   output logic                  dsram_rready
);

   typedef enum logic [2:0] {
      StIdle,
      StAr,
      StR,
      StAw,
      StW,
      StB,
      StDone
   } state_e;

   localparam logic [1:0] OpLoad  = 2'b01;
   localparam logic [1:0] OpStore = 2'b10;

   state_e                state_q, state_d;
   logic [2:0]            funct3_q, funct3_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  err_q, err_d;

   logic [DATA_WIDTH-1:0] rdata_shifted;
   logic [DATA_WIDTH-1:0] load_data;
   logic [2:0]            store_strb;

   // Align the addressed byte lane to bit 0, then sign/zero-extend by size.
   always_comb begin
      rdata_shifted = dsram_rdata >> {addr_q[1:0], 3'b000};
      case (funct3_q)
         3'b000:  load_data = {{(DATA_WIDTH-8){rdata_shifted[7]}}, rdata_shifted[7:0]};
         3'b001:  load_data = {{(DATA_WIDTH-16){rdata_shifted[15]}}, rdata_shifted[15:0]};
         3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, rdata_shifted[7:0]};
         3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, rdata_shifted[15:0]};
         default: load_data = rdata_shifted;
      endcase
   end

   // Store size code; anything that is not byte or half is treated as word.
   always_comb begin
      case (funct3_q[1:0])
         2'b00:   store_strb = 3'd1;
         2'b01:   store_strb = 3'd2;
         default: store_strb = 3'd4;
      endcase
   end

   // Next-state and datapath latch logic.
   always_comb begin
      state_d  = state_q;
      funct3_d = funct3_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      case (state_q)
         StIdle: begin
            if (in_valid) begin
               funct3_d = in_funct3;
               addr_d   = in_addr;
               wdata_d  = in_wdata;
               rdata_d  = '0;
               err_d    = 1'b0;
               case (in_op)
                  OpLoad:  state_d = StAr;
                  OpStore: state_d = StAw;
                  default: state_d = StDone;
               endcase
            end
         end
         StAr: if (dsram_arready) state_d = StR;
         StR: begin
            if (dsram_rvalid) begin
               rdata_d = load_data;
               err_d   = (dsram_rresp != 2'b00);
               state_d = StDone;
            end
         end
         StAw: if (dsram_awready) state_d = StW;
         StW:  if (dsram_wready) state_d = StB;
         StB: begin
            if (dsram_bvalid) begin
               err_d   = (dsram_bresp != 2'b00);
               state_d = StDone;
            end
         end
         StDone: if (out_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // State and latch registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= StIdle;
         funct3_q <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         funct3_q <= funct3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   // Handshake outputs are pure state decodes, so a valid cannot drop early.
   assign in_ready      = (state_q == StIdle);
   assign dsram_arvalid = (state_q == StAr);
   assign dsram_rready  = (state_q == StR);
   assign dsram_awvalid = (state_q == StAw);
   assign dsram_wvalid  = (state_q == StW);
   assign dsram_bready  = (state_q == StB);
   assign out_valid     = (state_q == StDone);

   assign dsram_araddr  = addr_q;
   assign dsram_awaddr  = addr_q;
   assign dsram_wdata   = wdata_q;
   assign dsram_wstrb   = store_strb;
   assign out_rdata     = rdata_q;
   assign out_err       = err_q;

endmodule

// File: tb/tb_ysyx_23060208_lsu.sv
// Directed bench for the LSU: drives the EXU side and plays a scripted
// data-SRAM slave, checking every observable step against hand values.
module tb_ysyx_23060208_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [1:0]  in_op;
   logic [2:0]  in_funct3;
   logic [31:0] in_addr, in_wdata;
   logic        out_valid, out_ready, out_err;
   logic [31:0] out_rdata;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [2:0]  wstrb;
   logic [1:0]  bresp, rresp;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ysyx_23060208_lsu #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(32)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_op        (in_op),
      .in_funct3    (in_funct3),
      .in_addr      (in_addr),
      .in_wdata     (in_wdata),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_rdata    (out_rdata),
      .out_err      (out_err),
      .dsram_awaddr (awaddr),
      .dsram_awvalid(awvalid),
      .dsram_awready(awready),
      .dsram_wdata  (wdata),
      .dsram_wstrb  (wstrb),
      .dsram_wvalid (wvalid),
      .dsram_wready (wready),
      .dsram_bresp  (bresp),
      .dsram_bvalid (bvalid),
      .dsram_bready (bready),
      .dsram_araddr (araddr),
      .dsram_arvalid(arvalid),
      .dsram_arready(arready),
      .dsram_rdata  (rdata),
      .dsram_rresp  (rresp),
      .dsram_rvalid (rvalid),
      .dsram_rready (rready)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
      check("in_ready before accept", {31'd0, in_ready}, 32'd1);
      in_valid  = 1'b1;
      in_op     = op;
      in_funct3 = f3;
      in_addr   = a;
      in_wdata  = wd;
      step();
      in_valid  = 1'b0;
      in_op     = 2'b00;
      in_addr   = 32'hDEAD_BEEF;
      in_wdata  = 32'hDEAD_BEEF;
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("in_ready after release", {31'd0, in_ready}, 32'd1);
      check("out_valid after release", {31'd0, out_valid}, 32'd0);
   endtask

   // Zero-wait load: AR, R, DONE on consecutive cycles.
   task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd,
                          input logic [1:0] resp, input logic [31:0] exp, input logic exp_err);
      arready = 1'b1;
      rvalid  = 1'b1;
      rdata   = rd;
      rresp   = resp;
      issue(2'b01, f3, a, 32'h0);
      check("ld arvalid", {31'd0, arvalid}, 32'd1);
      check("ld araddr", araddr, a);
      check("ld in_ready busy", {31'd0, in_ready}, 32'd0);
      step();
      check("ld rready", {31'd0, rready}, 32'd1);
      check("ld arvalid after hs", {31'd0, arvalid}, 32'd0);
      step();
      check("ld out_valid", {31'd0, out_valid}, 32'd1);
      check("ld out_rdata", out_rdata, exp);
      check("ld out_err", {31'd0, out_err}, {31'd0, exp_err});
      release_result();
   endtask

   // Zero-wait store: AW, W, B, DONE on consecutive cycles.
   task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                           input logic [1:0] resp, input logic [2:0] exp_strb,
                           input logic exp_err);
      awready = 1'b1;
      wready  = 1'b1;
      bvalid  = 1'b1;
      bresp   = resp;
      issue(2'b10, f3, a, wd);
      check("st awvalid", {31'd0, awvalid}, 32'd1);
      check("st awaddr", awaddr, a);
      check("st wvalid before aw hs", {31'd0, wvalid}, 32'd0);
      step();
      check("st wvalid", {31'd0, wvalid}, 32'd1);
      check("st wdata", wdata, wd);
      check("st wstrb", {29'd0, wstrb}, {29'd0, exp_strb});
      check("st awvalid after hs", {31'd0, awvalid}, 32'd0);
      step();
      check("st bready", {31'd0, bready}, 32'd1);
      check("st wvalid after hs", {31'd0, wvalid}, 32'd0);
      step();
      check("st out_valid", {31'd0, out_valid}, 32'd1);
      check("st out_rdata", out_rdata, 32'd0);
      check("st out_err", {31'd0, out_err}, {31'd0, exp_err});
      release_result();
   endtask

   initial begin
      rst = 1'b0;
      in_valid = 1'b0; in_op = 2'b00; in_funct3 = 3'b000; in_addr = '0; in_wdata = '0;
      out_ready = 1'b0;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; rdata = '0;
      step();
      step();
      rst = 1'b1;
      step();

      // Reset state
      check("rst in_ready", {31'd0, in_ready}, 32'd1);
      check("rst out_valid", {31'd0, out_valid}, 32'd0);
      check("rst arvalid", {31'd0, arvalid}, 32'd0);
      check("rst awvalid", {31'd0, awvalid}, 32'd0);
      check("rst out_rdata", out_rdata, 32'd0);
      check("rst out_err", {31'd0, out_err}, 32'd0);

      // Load extraction variants on the same bus word
      do_load(3'b000, 32'h8000_0003, 32'h80FF_FF11, 2'b00, 32'hFFFF_FF80, 1'b0); // LB
      do_load(3'b001, 32'h8000_0002, 32'h80FF_FF11, 2'b00, 32'hFFFF_80FF, 1'b0); // LH
      do_load(3'b101, 32'h8000_0000, 32'h80FF_FF11, 2'b00, 32'h0000_FF11, 1'b0); // LHU
      do_load(3'b100, 32'h8000_0001, 32'h80FF_FF11, 2'b00, 32'h0000_00FF, 1'b0); // LBU
      do_load(3'b000, 32'h8000_0000, 32'h80FF_FF11, 2'b00, 32'h0000_0011, 1'b0); // LB +
      do_load(3'b010, 32'h8000_0004, 32'h1234_5678, 2'b00, 32'h1234_5678, 1'b0); // LW

      // Stores
      do_store(3'b001, 32'h8000_0002, 32'h1234_ABCD, 2'b00, 3'd2, 1'b0); // SH
      do_store(3'b000, 32'h8000_0005, 32'h0000_00AA, 2'b00, 3'd1, 1'b0); // SB
      do_store(3'b111, 32'h8000_0008, 32'hCAFE_F00D, 2'b00, 3'd4, 1'b0); // undefined -> W

      // Read-address backpressure; rvalid high during AR must be ignored
      arready = 1'b0;
      rvalid  = 1'b1;
      rdata   = 32'h80FF_FF11;
      rresp   = 2'b00;
      issue(2'b01, 3'b010, 32'h8000_0010, 32'h0);
      for (int i = 0; i < 5; i++) begin
         check("stall arvalid", {31'd0, arvalid}, 32'd1);
         check("stall araddr", araddr, 32'h8000_0010);
         check("stall rready", {31'd0, rready}, 32'd0);
         step();
      end
      arready = 1'b1;
      check("stall arvalid last", {31'd0, arvalid}, 32'd1);
      step();
      check("stall rready after hs", {31'd0, rready}, 32'd1);
      step();
      check("stall out_rdata", out_rdata, 32'h80FF_FF11);
      release_result();

      // op none held by WBU backpressure; previous load data must be cleared
      issue(2'b00, 3'b010, 32'h8000_0020, 32'h0);
      for (int i = 0; i < 3; i++) begin
         check("none out_valid", {31'd0, out_valid}, 32'd1);
         check("none out_rdata", out_rdata, 32'd0);
         check("none in_ready", {31'd0, in_ready}, 32'd0);
         check("none arvalid", {31'd0, arvalid}, 32'd0);
         step();
      end
      check("none out_valid held", {31'd0, out_valid}, 32'd1);
      release_result();

      // op 11 behaves as none
      issue(2'b11, 3'b010, 32'h8000_0024, 32'h0);
      check("op11 out_valid", {31'd0, out_valid}, 32'd1);
      check("op11 awvalid", {31'd0, awvalid}, 32'd0);
      release_result();

      // Error response then clean store
      do_load(3'b010, 32'h8000_0030, 32'h0000_0001, 2'b10, 32'h0000_0001, 1'b1);
      do_store(3'b010, 32'h8000_0030, 32'h0000_0002, 2'b00, 3'd4, 1'b0);

      // Reset mid-store while the W beat is stalled
      awready = 1'b1;
      wready  = 1'b0;
      issue(2'b10, 3'b010, 32'h8000_0040, 32'h5555_AAAA);
      step();
      check("midrst wvalid before", {31'd0, wvalid}, 32'd1);
      rst = 1'b0;
      step();
      check("midrst wvalid", {31'd0, wvalid}, 32'd0);
      check("midrst awvalid", {31'd0, awvalid}, 32'd0);
      check("midrst bready", {31'd0, bready}, 32'd0);
      check("midrst arvalid", {31'd0, arvalid}, 32'd0);
      check("midrst rready", {31'd0, rready}, 32'd0);
      check("midrst out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst wdata cleared", wdata, 32'd0);
      rst = 1'b1;
      wready = 1'b1;
      step();
      check("postrst in_ready", {31'd0, in_ready}, 32'd1);
      check("postrst wvalid", {31'd0, wvalid}, 32'd0);

      // Unit still works after the abandoned transaction
      do_load(3'b100, 32'h8000_0003, 32'h80FF_FF11, 2'b00, 32'h0000_0080, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ysyx_23060208_lsu.md
YSYX_23060208_LSU -- requirements
Module: ysyx_23060208_lsu

Interface
REQ-001 SHALL have parameters DATA_WIDTH, default 32, data width, and ADDR_WIDTH, default 32, address width; all widths below use these defaults.
REQ-002 SHALL have port clk  in  1  the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst  in  1  synchronous, active-low reset (rst==0 at a rising clk edge resets).
REQ-004 SHALL have port in_valid  in  1  EXU request valid.
REQ-005 SHALL have port in_ready  out  1  LSU accepts a request.
REQ-006 SHALL have port in_op  in  2  operation: 00 none, 01 load, 10 store, 11 treated as none.
REQ-007 SHALL have port in_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL have port in_addr  in  32  byte address.
REQ-009 SHALL have port in_wdata  in  32  store data, right-aligned.
REQ-010 SHALL have port out_valid  out  1  result valid to WBU.
REQ-011 SHALL have port out_ready  in  1  WBU accepts the result.
REQ-012 SHALL have port out_rdata  out  32  extended load data (0 for store/none).
REQ-013 SHALL have port out_err  out  1  nonzero bresp/rresp seen for this request.
REQ-014 SHALL have port dsram_awaddr/awvalid  out  32/1  write-address channel; dsram_awready  in  1.
REQ-015 SHALL have port dsram_wdata/wstrb/wvalid  out  32/3/1  write-data channel; dsram_wready  in  1.
REQ-016 SHALL have port dsram_bresp/bvalid  in  2/1  write response; dsram_bready  out  1.
REQ-017 SHALL have port dsram_araddr/arvalid  out  32/1  read-address channel; dsram_arready  in  1.
REQ-018 SHALL have port dsram_rdata/rresp/rvalid  in  32/2/1  read response; dsram_rready  out  1.

Function
REQ-019 SHALL implement FSM states IDLE, AR, R, AW, W, B, DONE; in_ready=1 only in IDLE.
REQ-020 SHALL, in IDLE on in_valid, latch op/funct3/addr/wdata and go to AR (load), AW (store) or DONE (none) next cycle.
REQ-021 SHALL assert arvalid only in AR with araddr=latched addr; AR->R on arvalid&&arready; arvalid held, address stable, until handshake.
REQ-022 SHALL assert rready only in R; R->DONE on rvalid, capturing rdata and err=(rresp!=0).
REQ-023 SHALL issue store phases strictly in order: AW (awvalid) -> W (wvalid) -> B (bready), advancing on each valid&&ready; W never begins before the AW handshake.
REQ-024 SHALL drive awaddr=latched addr, wdata=latched wdata unshifted, wstrb=3'd1 (B), 3'd2 (H), 3'd4 (W); err=(bresp!=0) captured in B.
REQ-025 SHALL extract load data from dsram_rdata shifted right by 8*addr[1:0]; B/H sign-extend bit 7/15, BU/HU zero-extend, W unchanged.
REQ-026 SHALL hold out_valid=1 with stable out_rdata/out_err in DONE until out_ready; DONE->IDLE on out_ready.
REQ-027 SHALL take exactly one cycle IDLE->DONE for op none; minimum load latency IDLE->DONE is 3 cycles with zero-wait slave, store 4 cycles.
REQ-028 SHALL accept no new request while busy (single outstanding transaction); undefined funct3 SHALL behave as W.
REQ-029 SHALL never deassert a valid before its handshake, and SHALL ignore rvalid/bvalid outside R/B.

Reset
REQ-030 SHALL, on rst==0, enter IDLE and clear all dsram valids/readies, out_valid, out_err, out_rdata and latches to 0 next edge, including mid-transaction (pending slave beat abandoned).
REQ-031 SHALL drive in_ready=1 the first cycle after rst returns to 1.

Verification
REQ-032 LB addr 0x80000003, rdata 0x80FF_FF11, zero-wait -> out_rdata 0xFFFFFF80, out_valid 3 cycles after accept.
REQ-033 SH addr 0x80000002, wdata 0x1234ABCD -> awaddr 0x80000002, then wdata 0x1234ABCD wstrb 3'd2, then bready; out_valid after B.
REQ-034 Slave holds arready=0 5 cycles -> arvalid stays 1, araddr stable, no rready before handshake.
REQ-035 op none, out_ready=0 for 3 cycles -> out_valid held 3 cycles, out_rdata 0, in_ready 0 until released.
REQ-036 Load rresp=2'b10 -> out_err=1; next store bresp=0 -> out_err=0.
REQ-037 rst=0 while in W -> next cycle all valids 0, state IDLE, in_ready=1 after rst=1.
